// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory,
// and buffers {pc, instr} pairs in a 2-entry FIFO toward decode (valid/ready).
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  logic [ADDR_WIDTH-1:0] pc_p0;
  logic [ADDR_WIDTH-1:0] buf_pc_p1    [2];
  logic [DATA_WIDTH-1:0] buf_instr_p1 [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  pop;
  logic                  push;

  function automatic logic [ADDR_WIDTH-1:0] pc_incr(input logic [ADDR_WIDTH-1:0] pc);
    pc_incr = pc + ADDR_WIDTH'(4);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] pc);
    word_align = {pc[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign pop  = (count != 2'd0) && out_ready;
  assign push = !redirect_valid && ((count != 2'd2) || pop);

  // ---- stage p0: PC register drives the memory address ----
  assign instr_addr = pc_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      pc_p0 <= word_align(redirect_pc);
    end else if (push) begin
      pc_p0 <= pc_incr(pc_p0);
    end
  end

  // ---- stage p1: fetch buffer toward decode ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_p1[i]    <= '0;
        buf_instr_p1[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_pc_p1[wr_ptr]    <= pc_p0;
        buf_instr_p1[wr_ptr] <= instr;
        wr_ptr               <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_instr = buf_instr_p1[rd_ptr];
  assign out_pc    = buf_pc_p1[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: one instance at RESET_PC = 0 driven from a
// vector table, and one at RESET_PC = 32'hFFFF_FFF8 for PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_PC = 0
  logic        rst_n = 1'b0;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // Instance B: RESET_PC near the top of the address space
  logic        rst_n_b = 1'b0;
  logic [31:0] instr_addr_b;
  logic [31:0] instr_b;
  logic        out_valid_b;
  logic        out_ready_b = 1'b0;
  logic [31:0] out_instr_b;
  logic [31:0] out_pc_b;

  // memory word[i] = 32'h1000_0000 + i
  assign instr   = 32'h1000_0000 + (instr_addr >> 2);
  assign instr_b = 32'h1000_0000 + (instr_addr_b >> 2);

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_addr     (instr_addr),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n_b),
    .instr_addr     (instr_addr_b),
    .instr          (instr_b),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (out_valid_b),
    .out_ready      (out_ready_b),
    .out_instr      (out_instr_b),
    .out_pc         (out_pc_b)
  );

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic        chk_data;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic cd, input logic [31:0] epc,
                     input logic [31:0] ein, input logic [31:0] ea);
    vec_t v;
    v.rst_n = r;  v.ready = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.chk_data = cd; v.e_pc = epc; v.e_instr = ein; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  initial begin
    //   rst rdy rv rpc           vld chk pc            instr          addr
    add(0, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,         32'h0);   // 0 reset
    add(0, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,         32'h0);   // 1
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,        32'h0,         32'h0);   // 2 release
    add(1, 1, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h4);   // 3
    add(1, 1, 0, 32'h0,         1, 1, 32'h4,        32'h1000_0001, 32'h8);   // 4
    add(1, 1, 0, 32'h0,         1, 1, 32'h8,        32'h1000_0002, 32'hC);   // 5
    add(0, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,         32'h0);   // 6 reset
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,         32'h0);   // 7 backpressure
    add(1, 0, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h4);   // 8
    add(1, 0, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h8);   // 9 full
    add(1, 0, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h8);   // 10
    add(1, 0, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h8);   // 11
    add(1, 1, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h8);   // 12 release
    add(1, 1, 0, 32'h0,         1, 1, 32'h4,        32'h1000_0001, 32'hC);   // 13
    add(1, 1, 0, 32'h0,         1, 1, 32'h8,        32'h1000_0002, 32'h10);  // 14
    add(1, 0, 0, 32'h0,         1, 1, 32'hC,        32'h1000_0003, 32'h14);  // 15 full again
    add(1, 0, 1, 32'h40,        1, 1, 32'hC,        32'h1000_0003, 32'h14);  // 16 redirect
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,        32'h0,         32'h40);  // 17 flushed
    add(1, 1, 0, 32'h0,         1, 1, 32'h40,       32'h1000_0010, 32'h44);  // 18 target
    add(1, 1, 1, 32'h43,        1, 1, 32'h44,       32'h1000_0011, 32'h48);  // 19 redirect+pop
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,        32'h0,         32'h40);  // 20 aligned
    add(1, 0, 0, 32'h0,         1, 1, 32'h40,       32'h1000_0010, 32'h44);  // 21
    add(1, 0, 0, 32'h0,         1, 1, 32'h40,       32'h1000_0010, 32'h48);  // 22 count=2
    add(0, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,         32'h0);   // 23 mid reset
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,        32'h0,         32'h0);   // 24
    add(1, 1, 0, 32'h0,         1, 1, 32'h0,        32'h1000_0000, 32'h4);   // 25
    add(1, 1, 0, 32'h0,         1, 1, 32'h4,        32'h1000_0001, 32'h8);   // 26

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      check("out_valid",  i, {31'h0, out_valid}, {31'h0, vecs[i].e_valid});
      check("instr_addr", i, instr_addr, vecs[i].e_addr);
      if (vecs[i].chk_data) begin
        check("out_pc",    i, out_pc,    vecs[i].e_pc);
        check("out_instr", i, out_instr, vecs[i].e_instr);
      end
    end

    // PC wrap-around on instance B with ready held high
    begin
      logic [31:0] wrap_pc    [4];
      logic [31:0] wrap_instr [4];
      logic [31:0] wrap_addr  [4];
      wrap_pc    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      wrap_instr = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000, 32'h1000_0001};
      wrap_addr  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
      @(negedge clk);
      #1;
      check("wrap_reset_addr",  100, instr_addr_b, 32'hFFFF_FFF8);
      check("wrap_reset_valid", 100, {31'h0, out_valid_b}, 32'h0);
      @(negedge clk);
      rst_n_b     = 1'b1;
      out_ready_b = 1'b1;
      #1;
      check("wrap_first_valid", 101, {31'h0, out_valid_b}, 32'h0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        #1;
        check("wrap_valid", 102 + k, {31'h0, out_valid_b}, 32'h1);
        check("wrap_pc",    102 + k, out_pc_b,     wrap_pc[k]);
        check("wrap_instr", 102 + k, out_instr_b,  wrap_instr[k]);
        check("wrap_addr",  102 + k, instr_addr_b, wrap_addr[k]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
